ps2_rx_frame: RTL and testbench

//  PS/2 device-to-host serial frame receiver; upstream stage of the keyboard scan-code decoder.
//  - Synchronises and deglitches PS2_CLK/PS2_DAT; samples on PS2_CLK falling edges.
//  - Assembles 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
//  - Emits each good byte as received_data with a 1-cycle received_data_en strobe.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_edge.sv | 89 ++++++++
 rtl/ps2_rx_frame.sv | 178 +++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 receive path: frame FSM state encoding
// and frame geometry constants.
//
// Contents:
//   ps2_state_t     FSM states IDLE, DATA, PARITY, STOP
//   PS2_DATA_BITS   data bits per frame (8)
//   PS2_FRAME_BITS  total bits per frame incl. start/parity/stop (11)
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
// Brings one raw pad signal into the system clock domain through a
// SYNC_STAGES flip-flop chain. With DEGLITCH > 0 the synchronised value
// must hold a new level for DEGLITCH consecutive cycles before it is
// accepted; with DEGLITCH = 0 the synchronised value is used directly.
// A one-cycle strobe marks each accepted 1->0 transition.
//
// Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset (chain and filter reset to 1)
//   raw     in   asynchronous pad signal
//   level   out  synchronised (and filtered) level
//   fall    out  1-cycle strobe on accepted falling transition
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int DEGLITCH    = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw,
   output logic level,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;

   // Reset to 1 so an idle bus does not look like a falling edge on release.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   generate
      if (DEGLITCH == 0) begin : g_plain
         logic prev_q;

         always_ff @(posedge clk) begin
            if (!resetn) begin
               prev_q <= 1'b1;
            end else begin
               prev_q <= synced;
            end
         end

         assign level = synced;
         assign fall  = prev_q & ~synced;
      end else begin : g_filter
         localparam int CW = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;

         logic [CW-1:0] cnt_q;
         logic          level_q;
         logic          fall_q;

         // Count consecutive samples that disagree with the accepted level;
         // the DEGLITCH-th one flips the level. Any agreeing sample restarts
         // the count, so short glitches never reach the accepted level.
         always_ff @(posedge clk) begin
            if (!resetn) begin
               cnt_q   <= '0;
               level_q <= 1'b1;
               fall_q  <= 1'b0;
            end else begin
               fall_q <= 1'b0;
               if (synced != level_q) begin
                  if (cnt_q == CW'(DEGLITCH - 1)) begin
                     level_q <= synced;
                     cnt_q   <= '0;
                     fall_q  <= ~synced;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
         end

         assign level = level_q;
         assign fall  = fall_q;
      end
   endgenerate

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// PS/2 device-to-host frame receiver. Samples PS2_DAT on filtered PS2_CLK
// falling edges, assembles start + 8 data bits (LSB first) + parity + stop,
// and presents each good byte with a one-cycle strobe. Frames that stall
// longer than TIMEOUT_US between clock falls are aborted.
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose odd
// parity is wrong; otherwise the parity bit is consumed and ignored.
//
// Ports:
//   CLOCK_50          in   system clock
//   Resetn            in   synchronous active-low reset
//   PS2_CLK           in   raw PS/2 clock (receive only)
//   PS2_DAT           in   raw PS/2 data (receive only)
//   received_data     out  last good byte, held until the next good frame
//   received_data_en  out  1-cycle strobe, received_data valid same cycle
//   frame_error       out  1-cycle strobe on an aborted or bad frame
//   busy              out  high while a frame is in progress
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TIMEOUT_US  = 200,
   parameter int SYNC_STAGES = 2,
   parameter int DEGLITCH    = 4
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       frame_error,
   output logic       busy
);

   localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int TW             = $clog2(TIMEOUT_CYCLES);

   logic clk_fall;
   logic clk_level_unused;
   logic dat;
   logic dat_fall_unused;

   ps2_state_t               state_q, state_next;
   logic [PS2_DATA_BITS-1:0] shift_q, shift_next;
   logic [2:0]               cnt_q, cnt_next;
   logic [TW-1:0]            timer_q, timer_next;
   logic [7:0]               data_q, data_next;
   logic                     en_q, en_next;
   logic                     err_q, err_next;
   logic                     frame_ok;
`ifdef PS2_PARITY_CHECK_EN
   logic                     parity_q, parity_next;
`endif

   ps2_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEGLITCH    (DEGLITCH)
   ) u_clk_sync (
      .clk    (CLOCK_50),
      .resetn (Resetn),
      .raw    (PS2_CLK),
      .level  (clk_level_unused),
      .fall   (clk_fall)
   );

   // Data only needs synchronising: it is sampled well inside a stable
   // window, so a glitch filter would only add skew against the clock path.
   ps2_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEGLITCH    (0)
   ) u_dat_sync (
      .clk    (CLOCK_50),
      .resetn (Resetn),
      .raw    (PS2_DAT),
      .level  (dat),
      .fall   (dat_fall_unused)
   );

   // Stop bit must be 1; with checking enabled the 9 data+parity bits
   // must also contain an odd number of ones.
`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat & (^{shift_q, parity_q});
`else
   assign frame_ok = dat;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_next;
         shift_q <= shift_next;
         cnt_q   <= cnt_next;
         timer_q <= timer_next;
         data_q  <= data_next;
         en_q    <= en_next;
         err_q   <= err_next;
`ifdef PS2_PARITY_CHECK_EN
         parity_q <= parity_next;
`endif
      end
   end

   // A clock fall always takes priority over the timeout, so a fall landing
   // on the terminal count keeps the frame alive.
   always_comb begin
      state_next = state_q;
      shift_next = shift_q;
      cnt_next   = cnt_q;
      timer_next = timer_q;
      data_next  = data_q;
      en_next    = 1'b0;
      err_next   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_next = parity_q;
`endif

      if (state_q == IDLE) begin
         timer_next = '0;
         if (clk_fall && !dat) begin
            state_next = DATA;
            cnt_next   = '0;
            shift_next = '0;
         end
      end else if (clk_fall) begin
         timer_next = '0;
         case (state_q)
            DATA: begin
               shift_next[cnt_q] = dat;
               if (cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                  state_next = PARITY;
               end else begin
                  cnt_next = cnt_q + 3'd1;
               end
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               parity_next = dat;
`endif
               state_next = STOP;
            end
            STOP: begin
               if (frame_ok) begin
                  data_next = shift_q;
                  en_next   = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
         err_next   = 1'b1;
         state_next = IDLE;
         timer_next = '0;
      end else begin
         timer_next = timer_q + TW'(1);
      end
   end

   assign received_data    = data_q;
   assign received_data_en = en_q;
   assign frame_error      = err_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame
// Drives PS/2 frames into ps2_rx_frame and checks strobes, data, busy and
// timing against a frame-level reference model. The DUT runs with a 1 MHz
// nominal CLK_HZ so one system cycle stands for 1 us: a 40-cycle PS/2
// half-period and a 200-cycle timeout.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

   localparam int SYNC = 2;
   localparam int DEG  = 4;
   localparam int LAT  = SYNC + DEG + 1;
   localparam int HALF = 40;
   localparam int TO   = 200;

   logic       CLOCK_50 = 1'b0;
   logic       Resetn   = 1'b0;
   logic       PS2_CLK  = 1'b1;
   logic       PS2_DAT  = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       frame_error;
   logic       busy;

   ps2_rx_frame #(
      .CLK_HZ      (1_000_000),
      .TIMEOUT_US  (TO),
      .SYNC_STAGES (SYNC),
      .DEGLITCH    (DEG)
   ) dut (
      .CLOCK_50         (CLOCK_50),
      .Resetn           (Resetn),
      .PS2_CLK          (PS2_CLK),
      .PS2_DAT          (PS2_DAT),
      .received_data    (received_data),
      .received_data_en (received_data_en),
      .frame_error      (frame_error),
      .busy             (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Event recorder: every strobe seen on the outputs, plus protocol
   // violations (simultaneous strobes or strobes on consecutive cycles).
   logic [7:0] en_q[$];
   int         en_cyc_q[$];
   int         err_cnt      = 0;
   int         last_err_cyc = -1;
   int         violations   = 0;
   logic       prev_strobe  = 1'b0;

   always @(negedge CLOCK_50) begin
      if (received_data_en) begin
         en_q.push_back(received_data);
         en_cyc_q.push_back(cyc);
      end
      if (frame_error) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      if (received_data_en && frame_error) violations++;
      if (prev_strobe && (received_data_en || frame_error)) violations++;
      prev_strobe = received_data_en || frame_error;
   end

   // Reference model: last accepted byte and the frame acceptance rule.
   logic [7:0] model_data = 8'h00;

   function automatic bit frame_good(input bit bad_par, input bit bad_stop);
`ifdef PS2_PARITY_CHECK_EN
      return !bad_stop && !bad_par;
`else
      return !bad_stop;
`endif
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   int last_fall = 0;

   // Sends the first nbits of a frame; a 2-cycle low glitch is inserted in
   // the high phase before bit glitch_bit (-1 for none).
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         wait_cyc(HALF / 2);
         PS2_DAT = f[i];
         if (i == glitch_bit) begin
            wait_cyc(5);
            PS2_CLK = 1'b0;
            wait_cyc(2);
            PS2_CLK = 1'b1;
            wait_cyc(HALF / 2 - 7);
         end else begin
            wait_cyc(HALF / 2);
         end
         PS2_CLK   = 1'b0;
         last_fall = cyc;
         wait_cyc(HALF);
         PS2_CLK = 1'b1;
      end
      wait_cyc(HALF / 2);
      PS2_DAT = 1'b1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      wait_cyc(3);
      total++;
      if (received_data_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_en: got %b want 0", received_data_en); end
      total++;
      if (frame_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", frame_error); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++;
      if (received_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", received_data); end
      Resetn = 1'b1;
      wait_cyc(20);
   endtask

   task automatic test_single();
      int n0, e0;
      logic [7:0] got;
      n0 = en_q.size();
      e0 = err_cnt;
      send_bits(8'h1C, 1'b0, 1'b0, 11, -1);
      wait_cyc(40);
      model_data = 8'h1C;
      total++;
      if (en_q.size() != n0 + 1) begin bad++; $display("[TB] FAIL single_en_count: got %0d want %0d", en_q.size() - n0, 1); end
      got = (en_q.size() > n0) ? en_q[n0] : 8'hxx;
      total++;
      if (got !== 8'h1C) begin bad++; $display("[TB] FAIL single_data: got %h want 1c", got); end
      total++;
      if (en_q.size() <= n0 || en_cyc_q[n0] - last_fall != LAT) begin
         bad++;
         $display("[TB] FAIL single_latency: got %0d want %0d",
                  (en_q.size() > n0) ? en_cyc_q[n0] - last_fall : -1, LAT);
      end
      total++;
      if (err_cnt != e0) begin bad++; $display("[TB] FAIL single_err: got %0d want 0", err_cnt - e0); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int n0, e0;
      logic [7:0] g0, g1;
      n0 = en_q.size();
      e0 = err_cnt;
      send_bits(8'hF0, 1'b0, 1'b0, 11, -1);
      send_bits(8'h1C, 1'b0, 1'b0, 11, -1);
      wait_cyc(40);
      model_data = 8'h1C;
      total++;
      if (en_q.size() != n0 + 2) begin bad++; $display("[TB] FAIL b2b_en_count: got %0d want 2", en_q.size() - n0); end
      g0 = (en_q.size() > n0) ? en_q[n0] : 8'hxx;
      g1 = (en_q.size() > n0 + 1) ? en_q[n0+1] : 8'hxx;
      total++;
      if (g0 !== 8'hF0) begin bad++; $display("[TB] FAIL b2b_first: got %h want f0", g0); end
      total++;
      if (g1 !== 8'h1C) begin bad++; $display("[TB] FAIL b2b_second: got %h want 1c", g1); end
      total++;
      if (err_cnt != e0) begin bad++; $display("[TB] FAIL b2b_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_parity_error();
      int n0, e0, exp_en;
      logic [7:0] got;
      n0 = en_q.size();
      e0 = err_cnt;
      exp_en = frame_good(1'b1, 1'b0) ? 1 : 0;
      send_bits(8'h1C, 1'b1, 1'b0, 11, -1);
      wait_cyc(40);
      if (exp_en == 1) model_data = 8'h1C;
      total++;
      if (en_q.size() - n0 != exp_en) begin bad++; $display("[TB] FAIL parity_en_count: got %0d want %0d", en_q.size() - n0, exp_en); end
      total++;
      if (err_cnt - e0 != 1 - exp_en) begin bad++; $display("[TB] FAIL parity_err_count: got %0d want %0d", err_cnt - e0, 1 - exp_en); end
      got = received_data;
      total++;
      if (got !== model_data) begin bad++; $display("[TB] FAIL parity_data: got %h want %h", got, model_data); end
   endtask

   task automatic test_stop_error();
      int n0, e0;
      logic [7:0] got;
      n0 = en_q.size();
      e0 = err_cnt;
      send_bits(8'h29, 1'b0, 1'b1, 11, -1);
      wait_cyc(40);
      total++;
      if (err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL stop_err_count: got %0d want 1", err_cnt - e0); end
      total++;
      if (en_q.size() != n0) begin bad++; $display("[TB] FAIL stop_en_count: got %0d want 0", en_q.size() - n0); end
      send_bits(8'h29, 1'b0, 1'b0, 11, -1);
      wait_cyc(40);
      model_data = 8'h29;
      got = (en_q.size() > n0) ? en_q[n0] : 8'hxx;
      total++;
      if (got !== 8'h29) begin bad++; $display("[TB] FAIL stop_recover_data: got %h want 29", got); end
   endtask

   task automatic test_timeout();
      int n0, e0, gap;
      logic [7:0] got;
      n0 = en_q.size();
      e0 = err_cnt;
      send_bits(8'h29, 1'b0, 1'b0, 6, -1);
      wait_cyc(250 - HALF / 2);
      total++;
      if (err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
      gap = last_err_cyc - last_fall;
      total++;
      if (gap < TO || gap > TO + LAT + 8) begin bad++; $display("[TB] FAIL timeout_delay: got %0d want %0d..%0d", gap, TO, TO + LAT + 8); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_busy: got %b want 0", busy); end
      total++;
      if (en_q.size() != n0) begin bad++; $display("[TB] FAIL timeout_en: got %0d want 0", en_q.size() - n0); end
      send_bits(8'h29, 1'b0, 1'b0, 11, -1);
      wait_cyc(40);
      model_data = 8'h29;
      got = (en_q.size() > n0) ? en_q[n0] : 8'hxx;
      total++;
      if (got !== 8'h29) begin bad++; $display("[TB] FAIL timeout_recover_data: got %h want 29", got); end
   endtask

   task automatic test_glitch();
      int n0, e0;
      logic [7:0] got;
      n0 = en_q.size();
      e0 = err_cnt;
      // Glitch in IDLE with data low: accepting it would look like a start bit.
      wait_cyc(20);
      PS2_DAT = 1'b0;
      wait_cyc(5);
      PS2_CLK = 1'b0;
      wait_cyc(2);
      PS2_CLK = 1'b1;
      wait_cyc(20);
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_idle_busy: got %b want 0", busy); end
      PS2_DAT = 1'b1;
      wait_cyc(20);
      send_bits(8'h1C, 1'b0, 1'b0, 11, 4);
      wait_cyc(40);
      model_data = 8'h1C;
      got = (en_q.size() > n0) ? en_q[n0] : 8'hxx;
      total++;
      if (got !== 8'h1C || en_q.size() != n0 + 1) begin bad++; $display("[TB] FAIL glitch_frame: got %h x%0d want 1c x1", got, en_q.size() - n0); end
      total++;
      if (err_cnt != e0) begin bad++; $display("[TB] FAIL glitch_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_reset_mid_frame();
      int n0, e0;
      logic [7:0] got;
      send_bits(8'h1C, 1'b0, 1'b0, 5, -1);
      Resetn = 1'b0;
      wait_cyc(2);
      model_data = 8'h00;
      total++;
      if (busy !== 1'b0 || received_data !== 8'h00 || received_data_en !== 1'b0 || frame_error !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs: got busy=%b data=%h en=%b err=%b want all 0",
                  busy, received_data, received_data_en, frame_error);
      end
      n0 = en_q.size();
      e0 = err_cnt;
      Resetn = 1'b1;
      wait_cyc(300);
      total++;
      if (en_q.size() != n0 || err_cnt != e0) begin bad++; $display("[TB] FAIL midreset_strobes: got en=%0d err=%0d want 0 0", en_q.size() - n0, err_cnt - e0); end
      send_bits(8'h1C, 1'b0, 1'b0, 11, -1);
      wait_cyc(40);
      model_data = 8'h1C;
      got = (en_q.size() > n0) ? en_q[n0] : 8'hxx;
      total++;
      if (got !== 8'h1C) begin bad++; $display("[TB] FAIL midreset_recover: got %h want 1c", got); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         int n0, e0, kind, exp_en;
         logic [7:0] b, got;
         bit bp, bs;
         b    = 8'($urandom);
         kind = $urandom_range(0, 3);
         bp   = (kind == 2);
         bs   = (kind == 3);
         exp_en = frame_good(bp, bs) ? 1 : 0;
         n0 = en_q.size();
         e0 = err_cnt;
         send_bits(b, bp, bs, 11, -1);
         wait_cyc(30);
         if (exp_en == 1) model_data = b;
         total++;
         if (en_q.size() - n0 != exp_en || err_cnt - e0 != 1 - exp_en) begin
            bad++;
            $display("[TB] FAIL rand_strobes[%0d]: got en=%0d err=%0d want en=%0d err=%0d (byte %h kind %0d)",
                     k, en_q.size() - n0, err_cnt - e0, exp_en, 1 - exp_en, b, kind);
         end
         got = received_data;
         total++;
         if (got !== model_data) begin bad++; $display("[TB] FAIL rand_data[%0d]: got %h want %h", k, got, model_data); end
      end
   endtask

   task automatic test_protocol();
      total++;
      if (violations != 0) begin bad++; $display("[TB] FAIL strobe_protocol: got %0d violations want 0", violations); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity_error();
      test_stop_error();
      test_timeout();
      test_glitch();
      test_reset_mid_frame();
      test_random();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
